// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg
// Shared constants, read-controller state encoding and pointer helpers for
// the 8-entry synchronous FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int FIFO_DEPTH  = 8;
   localparam int FIFO_PTR_W  = 4;   // 3-bit address plus wrap bit
   localparam int FIFO_ADDR_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      FETCH = 2'd2,
      VALID = 2'd3
   } rd_state_t;

   // Binary to reflected Gray code.
   function automatic logic [FIFO_PTR_W-1:0] bin2gray(input logic [FIFO_PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// ============================================================================
// gray2bin
// Combinational Gray-to-binary pointer conversion: each binary bit is the
// XOR of all Gray bits at and above it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray2bin
   import fifo_pkg::*;
#(
   parameter int W = FIFO_PTR_W
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
// ============================================================================
// fifo_rd_ctrl
// Read-side controller of the 8-entry synchronous FIFO. Walks a Gray read
// pointer against the writer's Gray pointer, issues single-cycle reads to the
// storage array and presents words on a registered valid/ready port.
// Optional feature macro: FIFO_RD_ALMOST_EMPTY_EN (adds almost_empty output
// and the AE_LEVEL threshold parameter).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8
`ifdef FIFO_RD_ALMOST_EMPTY_EN
   ,
   parameter int AE_LEVEL = 2
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   flush,
   input  logic [FIFO_PTR_W-1:0]  wr_ptr_gray,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   mem_rd_en,
   output logic [FIFO_ADDR_W-1:0] mem_rd_addr,
   output logic [FIFO_PTR_W-1:0]  rd_ptr_gray,
   output logic [DATA_W-1:0]      dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   empty,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
   output logic                   almost_empty,
`endif
   output logic [FIFO_PTR_W-1:0]  count
);

   rd_state_t             state;
   rd_state_t             state_next;
   logic [FIFO_PTR_W-1:0] rd_bin;
   logic [FIFO_PTR_W-1:0] wr_bin;
   logic [FIFO_PTR_W-1:0] rd_gray_inc;
   logic                  read_issue;

   gray2bin #(.W(FIFO_PTR_W)) u_rd_g2b (.gray(rd_ptr_gray), .bin(rd_bin));
   gray2bin #(.W(FIFO_PTR_W)) u_wr_g2b (.gray(wr_ptr_gray), .bin(wr_bin));

   // Occupancy is the modulo-16 distance between the two binary pointers,
   // which stays correct across the wrap-bit toggle.
   assign empty       = (rd_ptr_gray == wr_ptr_gray);
   assign count       = wr_bin - rd_bin;
   assign mem_rd_addr = rd_bin[FIFO_ADDR_W-1:0];
   assign rd_gray_inc = bin2gray(rd_bin + 4'd1);

   // A read may start from an empty output register, or back-to-back with a
   // transfer out of VALID; never while empty or flushing.
   assign read_issue = ((state == READY) || ((state == VALID) && dout_ready))
                       && start && !empty && !flush;
   assign mem_rd_en  = read_issue;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode; flush overrides every transition.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = start ? READY : IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_next = READY;
            READY: begin
               if (read_issue)  state_next = FETCH;
               else if (!start) state_next = IDLE;
            end
            FETCH:   state_next = VALID;
            VALID: begin
               if (dout_ready) begin
                  if (read_issue) state_next = FETCH;
                  else if (start) state_next = READY;
                  else            state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Read pointer and output register; flush drops any word landing from an
   // in-flight fetch by simply not capturing it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_gray <= '0;
         dout        <= '0;
         dout_valid  <= 1'b0;
      end else if (flush) begin
         rd_ptr_gray <= wr_ptr_gray;
         dout        <= '0;
         dout_valid  <= 1'b0;
      end else begin
         if (read_issue) rd_ptr_gray <= rd_gray_inc;
         if (state == FETCH) begin
            dout       <= mem_rdata;
            dout_valid <= 1'b1;
         end else if ((state == VALID) && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
   // Registered low-water flag on the storage occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) almost_empty <= 1'b1;
      else        almost_empty <= (count <= 4'(AE_LEVEL));
   end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// ============================================================================
// tb_fifo_rd_ctrl
// Directed bench for fifo_rd_ctrl with a storage-array model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       flush;
   logic [3:0] wr_ptr_gray;
   logic [7:0] mem_rdata;
   logic       mem_rd_en;
   logic [2:0] mem_rd_addr;
   logic [3:0] rd_ptr_gray;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       empty;
   logic [3:0] count;

   int total  = 0;
   int passed = 0;

   logic [7:0] mem [8];

   always #5 clk = ~clk;

   fifo_rd_ctrl #(.DATA_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .flush       (flush),
      .wr_ptr_gray (wr_ptr_gray),
      .mem_rdata   (mem_rdata),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .rd_ptr_gray (rd_ptr_gray),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .empty       (empty),
      .count       (count)
   );

   // Synchronous storage model: data one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_rd_addr];
   end

   typedef struct {
      logic       st;
      logic       rdy;
      logic [3:0] wr;
      logic       rd_en;
      logic [2:0] addr;
      logic       emp;
      logic [3:0] cnt;
      logic       vld;
      logic [7:0] dat;
      logic [3:0] rdg;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else             passed++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; dout_ready = 1'b0; wr_ptr_gray = 4'b0000;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      cyc();
   endtask

   logic [7:0] exp_data [10];
   logic [2:0] exp_addr [9];

   initial begin
      int n_rd;
      int n_xf;
      mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h11; mem[3] = 8'h22;
      mem[4] = 8'h33; mem[5] = 8'h44; mem[6] = 8'h55; mem[7] = 8'h66;
      mem_rdata = 8'h00;

      // Two-word drain: start, ready, wr, rd_en, addr, empty, count, valid, dout, rd_gray
      vecs[0] = '{1'b1, 1'b1, 4'b0011, 1'b1, 3'd0, 1'b0, 4'd2, 1'b0, 8'h00, 4'b0000};
      vecs[1] = '{1'b1, 1'b1, 4'b0011, 1'b0, 3'd1, 1'b0, 4'd1, 1'b0, 8'h00, 4'b0001};
      vecs[2] = '{1'b1, 1'b1, 4'b0011, 1'b1, 3'd1, 1'b0, 4'd1, 1'b1, 8'hA5, 4'b0001};
      vecs[3] = '{1'b1, 1'b1, 4'b0011, 1'b0, 3'd2, 1'b1, 4'd0, 1'b0, 8'hA5, 4'b0011};
      vecs[4] = '{1'b1, 1'b1, 4'b0011, 1'b0, 3'd2, 1'b1, 4'd0, 1'b1, 8'h3C, 4'b0011};
      vecs[5] = '{1'b1, 1'b1, 4'b0011, 1'b0, 3'd2, 1'b1, 4'd0, 1'b0, 8'h3C, 4'b0011};

      exp_addr = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
      exp_data = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hA5, 8'h3C};

      do_reset();
      chk("reset_state", {rd_ptr_gray, dout, dout_valid, mem_rd_en, mem_rd_addr, empty, count},
          {4'b0000, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0});

      // Empty FIFO with start high: never a read.
      start = 1'b1; dout_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("idle_empty%0d", i), {mem_rd_en, empty, count, dout_valid},
             {1'b0, 1'b1, 4'd0, 1'b0});
         cyc();
      end

      // Table-driven two-word read.
      for (int i = 0; i < 6; i++) begin
         start = vecs[i].st; dout_ready = vecs[i].rdy; wr_ptr_gray = vecs[i].wr; flush = 1'b0;
         #1;
         chk($sformatf("vec%0d", i),
             {mem_rd_en, mem_rd_addr, empty, count, dout_valid, dout, rd_ptr_gray},
             {vecs[i].rd_en, vecs[i].addr, vecs[i].emp, vecs[i].cnt, vecs[i].vld, vecs[i].dat, vecs[i].rdg});
         cyc();
      end

      // Full FIFO, consumer stalled: one fetch then hold.
      do_reset();
      start = 1'b1; dout_ready = 1'b0; wr_ptr_gray = 4'b1100;
      #1; chk("full_idle", {mem_rd_en, empty, count}, {1'b0, 1'b0, 4'd8});
      cyc();
      #1; chk("full_issue", {mem_rd_en, mem_rd_addr, count}, {1'b1, 3'd0, 4'd8});
      cyc();
      #1; chk("full_fetch", {mem_rd_en, count}, {1'b0, 4'd7});
      cyc();
      for (int i = 0; i < 3; i++) begin
         #1; chk($sformatf("full_hold%0d", i), {dout_valid, dout, mem_rd_en, count, rd_ptr_gray},
                 {1'b1, 8'hA5, 1'b0, 4'd7, 4'b0001});
         cyc();
      end

      // Drain across the address wrap with two more words written.
      dout_ready = 1'b1; wr_ptr_gray = 4'b1111;
      n_rd = 0; n_xf = 0;
      for (int c = 0; c < 60 && n_xf < 10; c++) begin
         #1;
         if (mem_rd_en) begin
            if (n_rd < 9) chk($sformatf("drain_addr%0d", n_rd), 32'(mem_rd_addr), 32'(exp_addr[n_rd]));
            else          chk("drain_extra_read", 32'(n_rd), 32'd8);
            if (n_rd == 7) chk("wrap_ptr", {rd_ptr_gray, count}, {4'b1100, 4'd2});
            n_rd++;
         end
         if (dout_valid) begin
            chk($sformatf("drain_data%0d", n_xf), 32'(dout), 32'(exp_data[n_xf]));
            n_xf++;
         end
         cyc();
      end
      chk("drain_xfers", 32'(n_xf), 32'd10);
      chk("drain_reads", 32'(n_rd), 32'd9);
      #1; chk("drain_end", {rd_ptr_gray, empty, count}, {4'b1111, 1'b1, 4'd0});

      // Flush while a fetch is in flight with five words queued.
      dout_ready = 1'b0; wr_ptr_gray = 4'b1000;
      #1; chk("flush_pre", {mem_rd_en, mem_rd_addr, count}, {1'b1, 3'd2, 4'd5});
      cyc();
      flush = 1'b1;
      #1; chk("flush_noread", 32'(mem_rd_en), 32'd0);
      cyc();
      flush = 1'b0;
      #1; chk("flush_after", {rd_ptr_gray, count, empty, dout_valid, mem_rd_en},
              {4'b1000, 4'd0, 1'b1, 1'b0, 1'b0});
      cyc();
      #1; chk("flush_dropped", 32'(dout_valid), 32'd0);

      // Pointer wrap 0xF -> 0x0, then start dropped while holding a word.
      wr_ptr_gray = 4'b0001;
      #1; chk("wrapF_issue", {mem_rd_en, mem_rd_addr, count}, {1'b1, 3'd7, 4'd2});
      cyc();
      #1; chk("wrapF_fetch", {rd_ptr_gray, count}, {4'b0000, 4'd1});
      cyc();
      start = 1'b0;
      #1; chk("stop_hold", {dout_valid, dout, mem_rd_en}, {1'b1, 8'h66, 1'b0});
      cyc();
      dout_ready = 1'b1;
      #1; chk("stop_xfer", {dout_valid, dout, mem_rd_en}, {1'b1, 8'h66, 1'b0});
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1; chk($sformatf("stop_idle%0d", i), {dout_valid, mem_rd_en, count}, {1'b0, 1'b0, 4'd1});
         cyc();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
